// File: rtl/add_issue_sched.sv
// add_issue_sched: issue and writeback scheduler for the add/sub reservation
// stations. It picks ready entries round-robin, hands them to idle add units,
// times the fixed exec latency and arbitrates the single CDB among finishers.
// Optional perf counters are built when ADD_ISSUE_SCHED_PERF_EN is defined;
// otherwise perf_issue/perf_stall are tied to zero.
module add_issue_sched #(
  parameter int NUM_RS  = 3,
  parameter int NUM_EU  = 2,
  parameter int ADD_LAT = 2,
  parameter int DATA_W  = 8,
  parameter int REG_W   = 4,
  parameter int ROB_W   = 3
) (
  input  logic                       clk1,
  input  logic                       rst,
  input  logic [NUM_RS-1:0]          rs_busy,
  input  logic [NUM_RS-1:0]          rs_rdy1,
  input  logic [NUM_RS-1:0]          rs_rdy2,
  input  logic [4*NUM_RS-1:0]        rs_func,
  input  logic [REG_W*NUM_RS-1:0]    rs_rd,
  input  logic [ROB_W*NUM_RS-1:0]    rs_rob,
  input  logic [DATA_W*NUM_RS-1:0]   rs_v1,
  input  logic [DATA_W*NUM_RS-1:0]   rs_v2,
  output logic [NUM_EU-1:0]          eu_start,
  output logic [4*NUM_EU-1:0]        eu_func,
  output logic [DATA_W*NUM_EU-1:0]   eu_a,
  output logic [DATA_W*NUM_EU-1:0]   eu_b,
  input  logic [2*DATA_W*NUM_EU-1:0] eu_res,
  output logic                       cdb_valid,
  output logic [REG_W-1:0]           cdb_rd,
  output logic [ROB_W-1:0]           cdb_rob,
  output logic [2*DATA_W-1:0]        cdb_data,
  output logic [NUM_RS-1:0]          rs_clr,
  output logic                       err_func,
  output logic [15:0]                perf_issue,
  output logic [15:0]                perf_stall
);
  localparam int RS_IW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int EU_IW = (NUM_EU > 1) ? $clog2(NUM_EU) : 1;
  localparam int CNT_W = $clog2(ADD_LAT + 1);
  localparam int RES_W = 2 * DATA_W;

  typedef enum logic [1:0] {EU_IDLE, EU_EXEC, EU_WB} eu_st_e;

  eu_st_e             st_q   [NUM_EU];
  logic [CNT_W-1:0]   cnt_q  [NUM_EU];
  logic [RS_IW-1:0]   idx_q  [NUM_EU];
  logic [REG_W-1:0]   rd_q   [NUM_EU];
  logic [ROB_W-1:0]   rob_q  [NUM_EU];
  logic [RES_W-1:0]   res_q  [NUM_EU];

  logic [NUM_RS-1:0]  inflight_q, inflight_d;
  logic [RS_IW-1:0]   rs_ptr_q, rs_ptr_d;
  logic [EU_IW-1:0]   gnt_ptr_q, gnt_ptr_d;
  logic [NUM_EU-1:0]  eu_start_q;
  logic [4*NUM_EU-1:0]      eu_func_q;
  logic [DATA_W*NUM_EU-1:0] eu_a_q, eu_b_q;
  logic               cdb_valid_q;
  logic [REG_W-1:0]   cdb_rd_q;
  logic [ROB_W-1:0]   cdb_rob_q;
  logic [RES_W-1:0]   cdb_data_q;
  logic [NUM_RS-1:0]  rs_clr_q;
  logic               err_q;

  logic [NUM_RS-1:0]  elig, bad;
  logic               iss_v, eu_free;
  logic [RS_IW-1:0]   iss_idx;
  logic [EU_IW-1:0]   iss_eu;
  logic [NUM_EU-1:0]  wb_req, gnt_oh;
  logic               gnt_v;
  logic [EU_IW-1:0]   gnt_eu;

  // Classify entries: issuable add/sub (func 000x) vs ready with an illegal func.
  always_comb begin
    elig = '0;
    bad  = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      elig[i] = rs_busy[i] & rs_rdy1[i] & rs_rdy2[i] & ~inflight_q[i] &
                (rs_func[4*i+1 +: 3] == 3'b000);
      bad[i]  = rs_busy[i] & rs_rdy1[i] & rs_rdy2[i] &
                (rs_func[4*i+1 +: 3] != 3'b000);
    end
  end

  // Round-robin entry pick starting at rs_ptr_q, paired with the lowest idle unit.
  always_comb begin
    logic [RS_IW-1:0] ri;
    ri      = '0;
    iss_v   = 1'b0;
    iss_idx = '0;
    eu_free = 1'b0;
    iss_eu  = '0;
    for (int u = NUM_EU - 1; u >= 0; u--) begin
      if (st_q[u] == EU_IDLE) begin
        eu_free = 1'b1;
        iss_eu  = EU_IW'(u);
      end
    end
    for (int k = 0; k < NUM_RS; k++) begin
      ri = RS_IW'((int'(rs_ptr_q) + k) % NUM_RS);
      if (!iss_v && elig[ri]) begin
        iss_v   = 1'b1;
        iss_idx = ri;
      end
    end
    iss_v = iss_v & eu_free;
  end

  // Round-robin CDB grant among units holding a finished result.
  always_comb begin
    logic [EU_IW-1:0] ui;
    ui     = '0;
    gnt_v  = 1'b0;
    gnt_eu = '0;
    wb_req = '0;
    gnt_oh = '0;
    for (int u = 0; u < NUM_EU; u++) wb_req[u] = (st_q[u] == EU_WB);
    for (int k = 0; k < NUM_EU; k++) begin
      ui = EU_IW'((int'(gnt_ptr_q) + k) % NUM_EU);
      if (!gnt_v && wb_req[ui]) begin
        gnt_v  = 1'b1;
        gnt_eu = ui;
      end
    end
    if (gnt_v) gnt_oh[gnt_eu] = 1'b1;
  end

  assign rs_ptr_d  = (iss_idx == RS_IW'(NUM_RS - 1)) ? '0 : iss_idx + 1'b1;
  assign gnt_ptr_d = (gnt_eu == EU_IW'(NUM_EU - 1)) ? '0 : gnt_eu + 1'b1;

  // In-flight mask: retiring entry released, newly issued entry claimed.
  always_comb begin
    inflight_d = inflight_q;
    if (gnt_v) inflight_d[idx_q[gnt_eu]] = 1'b0;
    if (iss_v) inflight_d[iss_idx] = 1'b1;
  end

  // Unit FSMs, pointers and all registered outputs.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < NUM_EU; u++) begin
        st_q[u]  <= EU_IDLE;
        cnt_q[u] <= '0;
      end
      inflight_q  <= '0;
      rs_ptr_q    <= '0;
      gnt_ptr_q   <= '0;
      eu_start_q  <= '0;
      eu_func_q   <= '0;
      eu_a_q      <= '0;
      eu_b_q      <= '0;
      cdb_valid_q <= 1'b0;
      cdb_rd_q    <= '0;
      cdb_rob_q   <= '0;
      cdb_data_q  <= '0;
      rs_clr_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      eu_start_q  <= '0;
      cdb_valid_q <= 1'b0;
      rs_clr_q    <= '0;
      err_q       <= err_q | (|bad);
      inflight_q  <= inflight_d;
      for (int u = 0; u < NUM_EU; u++) begin
        case (st_q[u])
          EU_EXEC: begin
            if (cnt_q[u] == CNT_W'(1)) st_q[u] <= EU_WB;
            else                       cnt_q[u] <= cnt_q[u] - 1'b1;
          end
          EU_WB:   if (gnt_oh[u]) st_q[u] <= EU_IDLE;
          default: ;
        endcase
      end
      if (gnt_v) begin
        cdb_valid_q <= 1'b1;
        cdb_rd_q    <= rd_q[gnt_eu];
        cdb_rob_q   <= rob_q[gnt_eu];
        cdb_data_q  <= res_q[gnt_eu];
        rs_clr_q[idx_q[gnt_eu]] <= 1'b1;
        gnt_ptr_q   <= gnt_ptr_d;
      end
      // A unit granted this edge is not IDLE in st_q yet, so it cannot be reused here.
      if (iss_v) begin
        st_q[iss_eu]       <= EU_EXEC;
        cnt_q[iss_eu]      <= CNT_W'(ADD_LAT);
        eu_start_q[iss_eu] <= 1'b1;
        eu_func_q[4*iss_eu +: 4]         <= rs_func[4*iss_idx +: 4];
        eu_a_q[DATA_W*iss_eu +: DATA_W]  <= rs_v1[DATA_W*iss_idx +: DATA_W];
        eu_b_q[DATA_W*iss_eu +: DATA_W]  <= rs_v2[DATA_W*iss_idx +: DATA_W];
        rs_ptr_q <= rs_ptr_d;
      end
    end
  end

  // Per-unit payload: tags captured at issue, result captured on the last exec cycle.
  always_ff @(posedge clk1) begin
    if (iss_v) begin
      idx_q[iss_eu] <= iss_idx;
      rd_q[iss_eu]  <= rs_rd[REG_W*iss_idx +: REG_W];
      rob_q[iss_eu] <= rs_rob[ROB_W*iss_idx +: ROB_W];
    end
    for (int u = 0; u < NUM_EU; u++) begin
      if (st_q[u] == EU_EXEC && cnt_q[u] == CNT_W'(1))
        res_q[u] <= eu_res[RES_W*u +: RES_W];
    end
  end

  assign eu_start  = eu_start_q;
  assign eu_func   = eu_func_q;
  assign eu_a      = eu_a_q;
  assign eu_b      = eu_b_q;
  assign cdb_valid = cdb_valid_q;
  assign cdb_rd    = cdb_rd_q;
  assign cdb_rob   = cdb_rob_q;
  assign cdb_data  = cdb_data_q;
  assign rs_clr    = rs_clr_q;
  assign err_func  = err_q;

`ifdef ADD_ISSUE_SCHED_PERF_EN
  logic [15:0] perf_issue_q, perf_stall_q;
  logic        stall;
  assign stall = |(wb_req & ~gnt_oh);

  // Saturating issue and CDB-stall counters.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (iss_v && perf_issue_q != 16'hFFFF) perf_issue_q <= perf_issue_q + 16'd1;
      if (stall && perf_stall_q != 16'hFFFF) perf_stall_q <= perf_stall_q + 16'd1;
    end
  end

  assign perf_issue = perf_issue_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_issue = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_add_issue_sched.sv
// Self-checking bench for add_issue_sched: directed scenarios followed by a
// randomized reservation-station workload checked against a timestamp-based
// reference model of the scheduler.
`timescale 1ns/1ps
module tb_add_issue_sched;
  localparam int NUM_RS  = 3;
  localparam int NUM_EU  = 2;
  localparam int ADD_LAT = 2;
  localparam int DATA_W  = 8;
  localparam int REG_W   = 4;
  localparam int ROB_W   = 3;
  localparam int RES_W   = 2 * DATA_W;

  logic clk1 = 1'b0;
  logic rst  = 1'b0;
  always #5 clk1 = ~clk1;

  // Reservation-station contents driven by the bench
  logic [NUM_RS-1:0] busy, rdy1, rdy2;
  logic [3:0]        fn  [NUM_RS];
  logic [REG_W-1:0]  rd  [NUM_RS];
  logic [ROB_W-1:0]  rob [NUM_RS];
  logic [DATA_W-1:0] v1  [NUM_RS];
  logic [DATA_W-1:0] v2  [NUM_RS];

  logic [4*NUM_RS-1:0]        rs_func;
  logic [REG_W*NUM_RS-1:0]    rs_rd;
  logic [ROB_W*NUM_RS-1:0]    rs_rob;
  logic [DATA_W*NUM_RS-1:0]   rs_v1, rs_v2;
  logic [NUM_EU-1:0]          eu_start;
  logic [4*NUM_EU-1:0]        eu_func;
  logic [DATA_W*NUM_EU-1:0]   eu_a, eu_b;
  logic [RES_W*NUM_EU-1:0]    eu_res;
  logic                       cdb_valid;
  logic [REG_W-1:0]           cdb_rd;
  logic [ROB_W-1:0]           cdb_rob;
  logic [RES_W-1:0]           cdb_data;
  logic [NUM_RS-1:0]          rs_clr;
  logic                       err_func;
  logic [15:0]                perf_issue, perf_stall;

  always_comb begin
    rs_func = '0; rs_rd = '0; rs_rob = '0; rs_v1 = '0; rs_v2 = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      rs_func[4*i +: 4]          = fn[i];
      rs_rd[REG_W*i +: REG_W]    = rd[i];
      rs_rob[ROB_W*i +: ROB_W]   = rob[i];
      rs_v1[DATA_W*i +: DATA_W]  = v1[i];
      rs_v2[DATA_W*i +: DATA_W]  = v2[i];
    end
  end

  // Add execution units: combinational add/sub of the latched operands
  always_comb begin
    eu_res = '0;
    for (int u = 0; u < NUM_EU; u++) begin
      if (eu_func[4*u +: 4] == 4'h1)
        eu_res[RES_W*u +: RES_W] = {8'h00, eu_a[DATA_W*u +: DATA_W]} - {8'h00, eu_b[DATA_W*u +: DATA_W]};
      else
        eu_res[RES_W*u +: RES_W] = {8'h00, eu_a[DATA_W*u +: DATA_W]} + {8'h00, eu_b[DATA_W*u +: DATA_W]};
    end
  end

  add_issue_sched #(
    .NUM_RS(NUM_RS), .NUM_EU(NUM_EU), .ADD_LAT(ADD_LAT),
    .DATA_W(DATA_W), .REG_W(REG_W), .ROB_W(ROB_W)
  ) dut (
    .clk1(clk1), .rst(rst),
    .rs_busy(busy), .rs_rdy1(rdy1), .rs_rdy2(rdy2),
    .rs_func(rs_func), .rs_rd(rs_rd), .rs_rob(rs_rob),
    .rs_v1(rs_v1), .rs_v2(rs_v2),
    .eu_start(eu_start), .eu_func(eu_func), .eu_a(eu_a), .eu_b(eu_b),
    .eu_res(eu_res),
    .cdb_valid(cdb_valid), .cdb_rd(cdb_rd), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
    .rs_clr(rs_clr), .err_func(err_func),
    .perf_issue(perf_issue), .perf_stall(perf_stall)
  );

  // Reference model: each busy unit remembers the edge it was issued on; it
  // competes for the CDB from edge issue+ADD_LAT+1 onward.
  int                n_cmp = 0;
  int                n_bad = 0;
  int                t = 0;
  bit                m_busy  [NUM_EU];
  int                m_iss_t [NUM_EU];
  int                m_idx   [NUM_EU];
  logic [3:0]        m_fn    [NUM_EU];
  logic [REG_W-1:0]  m_rd    [NUM_EU];
  logic [ROB_W-1:0]  m_rob   [NUM_EU];
  logic [DATA_W-1:0] m_a     [NUM_EU];
  logic [DATA_W-1:0] m_b     [NUM_EU];
  bit                m_infl  [NUM_RS];
  int                m_rptr, m_gptr, m_pi, m_ps;
  bit                m_err;
  logic [NUM_EU-1:0] x_start;
  bit                x_cv;
  logic [REG_W-1:0]  x_rd;
  logic [ROB_W-1:0]  x_rob;
  logic [RES_W-1:0]  x_data;
  logic [NUM_RS-1:0] x_clr;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < NUM_EU; u++) begin
      m_busy[u] = 0; m_iss_t[u] = 0; m_idx[u] = 0;
      m_fn[u] = '0; m_rd[u] = '0; m_rob[u] = '0; m_a[u] = '0; m_b[u] = '0;
    end
    for (int i = 0; i < NUM_RS; i++) m_infl[i] = 0;
    m_rptr = 0; m_gptr = 0; m_pi = 0; m_ps = 0; m_err = 0;
    x_start = '0; x_cv = 0; x_rd = '0; x_rob = '0; x_data = '0; x_clr = '0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    int req_n, w, iss_i, iss_u, i;
    t++;
    req_n = 0; w = -1; iss_i = -1; iss_u = -1;
    for (int k = 0; k < NUM_EU; k++) begin
      int u;
      u = (m_gptr + k) % NUM_EU;
      if (m_busy[u] && t >= m_iss_t[u] + ADD_LAT + 1) begin
        req_n++;
        if (w < 0) w = u;
      end
    end
    for (int k = 0; k < NUM_RS; k++) begin
      i = (m_rptr + k) % NUM_RS;
      if (iss_i < 0 && busy[i] && rdy1[i] && rdy2[i] && !m_infl[i] && fn[i] < 4'd2) iss_i = i;
    end
    for (int u = 0; u < NUM_EU; u++)
      if (iss_u < 0 && !m_busy[u]) iss_u = u;
    for (int j = 0; j < NUM_RS; j++)
      if (busy[j] && rdy1[j] && rdy2[j] && fn[j] >= 4'd2) m_err = 1;
    x_start = '0; x_cv = 0; x_clr = '0;
    if (w >= 0) begin
      x_cv   = 1;
      x_rd   = m_rd[w];
      x_rob  = m_rob[w];
      x_data = (m_fn[w] == 4'h1) ? RES_W'(m_a[w]) - RES_W'(m_b[w]) : RES_W'(m_a[w]) + RES_W'(m_b[w]);
      x_clr[m_idx[w]] = 1'b1;
      m_infl[m_idx[w]] = 0;
      m_busy[w] = 0;
      m_gptr = (w + 1) % NUM_EU;
      if (req_n > 1 && m_ps < 65535) m_ps++;
    end
    if (iss_i >= 0 && iss_u >= 0) begin
      x_start[iss_u] = 1'b1;
      m_busy[iss_u]  = 1;
      m_iss_t[iss_u] = t;
      m_idx[iss_u]   = iss_i;
      m_fn[iss_u]    = fn[iss_i];
      m_rd[iss_u]    = rd[iss_i];
      m_rob[iss_u]   = rob[iss_i];
      m_a[iss_u]     = v1[iss_i];
      m_b[iss_u]     = v2[iss_i];
      m_infl[iss_i]  = 1;
      m_rptr = (iss_i + 1) % NUM_RS;
      if (m_pi < 65535) m_pi++;
    end
  endtask

  task automatic check_all();
    logic [4*NUM_EU-1:0]      ef;
    logic [DATA_W*NUM_EU-1:0] ea, eb;
    for (int u = 0; u < NUM_EU; u++) begin
      ef[4*u +: 4]           = m_fn[u];
      ea[DATA_W*u +: DATA_W] = m_a[u];
      eb[DATA_W*u +: DATA_W] = m_b[u];
    end
    chk("eu_start", eu_start, x_start);
    chk("eu_func", eu_func, ef);
    chk("eu_a", eu_a, ea);
    chk("eu_b", eu_b, eb);
    chk("cdb_valid", cdb_valid, x_cv);
    if (x_cv) chk("cdb_payload", {cdb_rd, cdb_rob, cdb_data}, {x_rd, x_rob, x_data});
    chk("rs_clr", rs_clr, x_clr);
    chk("err_func", err_func, m_err);
`ifdef ADD_ISSUE_SCHED_PERF_EN
    chk("perf_issue", perf_issue, 16'(m_pi));
    chk("perf_stall", perf_stall, 16'(m_ps));
`else
    chk("perf_issue", perf_issue, 16'h0);
    chk("perf_stall", perf_stall, 16'h0);
`endif
  endtask

  // One clock: model the edge, let it happen, compare at the falling edge,
  // then let the RS array drop any entry the scheduler just freed.
  task automatic tick();
    model_edge();
    @(posedge clk1);
    @(negedge clk1);
    check_all();
    for (int i = 0; i < NUM_RS; i++) if (x_clr[i]) busy[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    busy = '0; rdy1 = '0; rdy2 = '0;
    #1;
    model_reset();
    check_all();
    chk("rst_cdb_payload", {cdb_rd, cdb_rob, cdb_data}, '0);
    @(negedge clk1);
    rst = 1'b0;
  endtask

  task automatic load(int i, logic [3:0] f, logic [DATA_W-1:0] a, logic [DATA_W-1:0] b,
                      logic [REG_W-1:0] d, logic [ROB_W-1:0] r, bit r1, bit r2);
    busy[i] = 1'b1; rdy1[i] = r1; rdy2[i] = r2;
    fn[i] = f; v1[i] = a; v2[i] = b; rd[i] = d; rob[i] = r;
  endtask

  task automatic rand_rs();
    for (int i = 0; i < NUM_RS; i++) begin
      if (!busy[i]) begin
        if ($urandom_range(2) == 0)
          load(i, 4'($urandom_range(1)), DATA_W'($urandom), DATA_W'($urandom),
               REG_W'($urandom), ROB_W'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
      end else begin
        if (!rdy1[i] && $urandom_range(2) == 0) rdy1[i] = 1'b1;
        if (!rdy2[i] && $urandom_range(2) == 0) rdy2[i] = 1'b1;
        if ($urandom_range(9) == 0) begin
          v1[i] = DATA_W'($urandom);
          v2[i] = DATA_W'($urandom);
        end
        if ($urandom_range(39) == 0) busy[i] = 1'b0;
      end
    end
  endtask

  initial begin
    busy = '0; rdy1 = '0; rdy2 = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      fn[i] = '0; rd[i] = '0; rob[i] = '0; v1[i] = '0; v2[i] = '0;
    end
    #2;
    do_reset();

    // Single add: 5+3 to rd 4 / rob 2
    load(0, 4'h0, 8'h05, 8'h03, 4'd4, 3'd2, 1, 1);
    tick();
    chk("single_start", eu_start, 2'b01);
    tick(); tick(); tick();
    chk("single_cdb", {cdb_valid, cdb_rd, cdb_rob, cdb_data}, {1'b1, 4'd4, 3'd2, 16'h0008});
    chk("single_clr", rs_clr, 3'b001);
    tick();

    // Three ready entries, two units
    do_reset();
    load(0, 4'h0, 8'h10, 8'h01, 4'd1, 3'd1, 1, 1);
    load(1, 4'h1, 8'h20, 8'h02, 4'd2, 3'd2, 1, 1);
    load(2, 4'h0, 8'h30, 8'h03, 4'd3, 3'd3, 1, 1);
    tick(); chk("three_e1", eu_start, 2'b01);
    tick(); chk("three_e2", eu_start, 2'b10);
    tick(); tick();
    chk("three_e4_cdb", {cdb_valid, cdb_rob, cdb_data}, {1'b1, 3'd1, 16'h0011});
    tick();
    chk("three_e5_reissue", {eu_start, eu_a[7:0]}, {2'b01, 8'h30});
    for (int n = 0; n < 5; n++) tick();

    // Illegal function: never issued, sticky error
    do_reset();
    load(0, 4'h2, 8'h11, 8'h22, 4'd5, 3'd4, 1, 1);
    tick(); tick(); tick();
    chk("badfn_err", err_func, 1'b1);
    busy[0] = 1'b0;
    tick(); tick();
    chk("badfn_sticky", err_func, 1'b1);

    // Reset while unit 0 executes, then re-present the entry
    do_reset();
    load(0, 4'h0, 8'h40, 8'h04, 4'd6, 3'd6, 1, 1);
    tick(); tick();
    do_reset();
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("post_rst_quiet", cdb_valid, 1'b0);
    end
    load(0, 4'h0, 8'h40, 8'h04, 4'd6, 3'd6, 1, 1);
    tick(); chk("represent_start", eu_start, 2'b01);
    tick(); tick(); tick();
    chk("represent_cdb", {cdb_valid, cdb_data}, {1'b1, 16'h0044});

    // Operand not ready, then ready
    do_reset();
    load(0, 4'h1, 8'h03, 8'h05, 4'd7, 3'd5, 1, 0);
    tick(); tick();
    chk("rdy2_wait", eu_start, 2'b00);
    rdy2[0] = 1'b1;
    tick();
    chk("rdy2_issue", eu_start, 2'b01);
    tick(); tick(); tick();
    chk("sub_cdb", {cdb_valid, cdb_rd, cdb_data}, {1'b1, 4'd7, 16'hFFFE});

    // Randomized workload with one mid-run reset
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      rand_rs();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
